// File: rtl/audio_volume_mixer_pkg.sv
// Shared types for the stereo volume/crossfeed stage: the four-factor volume
// word, FSM encoding and the shift/saturate helper.
package audio_volume_mixer_pkg;

   // Mix factors, 8-bit unsigned each, 0x80 = unity. l2l sits in the low byte.
   typedef struct packed {
      logic [7:0] r2r;
      logic [7:0] l2r;
      logic [7:0] r2l;
      logic [7:0] l2l;
   } linear_volume_s;

   localparam bit [7:0] VOLUME_UNITY = 8'h80;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      M_LL = 3'd1,
      M_RL = 3'd2,
      M_LR = 3'd3,
      M_RR = 3'd4,
      OUT  = 3'd5
   } mix_state_e;

   // Drop the 7 fractional factor bits (floor) and clamp to the 16-bit range.
   function automatic logic signed [15:0] sat_shift(input logic signed [25:0] acc);
      logic signed [25:0] sh;
      sh = acc >>> 7;
      if (sh > 26'sd32767)
         return 16'sh7fff;
      else if (sh < -26'sd32768)
         return 16'sh8000;
      else
         return sh[15:0];
   endfunction

endpackage

// File: rtl/audio_volume_mixer_ramp.sv
// Effective-factor ramp: four 8-bit registers that each step by one toward
// the requested volume on every accepted input pair. Used only when
// AUDIO_VOLUME_RAMP_EN is defined; removes zipper noise on volume changes.
module audio_volume_ramp
   import audio_volume_mixer_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  linear_volume_s target,
   input  logic           step,
   output linear_volume_s factor
);

   function automatic logic [7:0] toward(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt)
         return cur + 8'd1;
      else if (cur > tgt)
         return cur - 8'd1;
      else
         return cur;
   endfunction

   // Step every factor once per accepted pair; reset returns to straight unity.
   always_ff @(posedge clk) begin
      if (reset) begin
         factor.l2l <= VOLUME_UNITY;
         factor.r2r <= VOLUME_UNITY;
         factor.l2r <= 8'h00;
         factor.r2l <= 8'h00;
      end else if (step) begin
         factor.l2l <= toward(factor.l2l, target.l2l);
         factor.r2l <= toward(factor.r2l, target.r2l);
         factor.l2r <= toward(factor.l2r, target.l2r);
         factor.r2r <= toward(factor.r2r, target.r2r);
      end
   end

endmodule

// File: rtl/audio_volume_mixer.sv
// Stereo volume/crossfeed stage. One shared 17x9 multiplier is stepped over
// the four products L*l2l, R*r2l, L*l2r, R*r2r; results are scaled by 1/128
// and saturated to 16 bits. Optional factor ramp: AUDIO_VOLUME_RAMP_EN.
module audio_volume_mixer
   import audio_volume_mixer_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  linear_volume_s      volume,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [15:0]  in_left,
   input  logic signed [15:0]  in_right,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [15:0]  out_left,
   output logic signed [15:0]  out_right
);

   mix_state_e         state, state_nxt;
   linear_volume_s     eff_vol;
   linear_volume_s     fac;
   logic signed [15:0] smp_l, smp_r;
   logic signed [25:0] acc_l, acc_r;
   logic signed [25:0] prod_ext, sum_r;
   logic signed [24:0] mul_a, mul_b, prod;
   logic signed [15:0] mul_smp;
   logic [7:0]         mul_fac;
   logic               in_hs;

   assign in_hs = in_valid & in_ready;

`ifdef AUDIO_VOLUME_RAMP_EN
   // Ramped factors; the pre-step value is what the accepted pair uses.
   audio_volume_ramp u_ramp (
      .clk    (clk),
      .reset  (reset),
      .target (volume),
      .step   (in_hs),
      .factor (eff_vol)
   );
`else
   assign eff_vol = volume;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: four multiply steps, then hold OUT until the consumer takes it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = M_LL;
         M_LL:    state_nxt = M_RL;
         M_RL:    state_nxt = M_LR;
         M_LR:    state_nxt = M_RR;
         M_RR:    state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decode directly from state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == OUT);
   end

   // Multiplier operand select for the current product.
   always_comb begin
      mul_smp = '0;
      mul_fac = '0;
      case (state)
         M_LL:    begin mul_smp = smp_l; mul_fac = fac.l2l; end
         M_RL:    begin mul_smp = smp_r; mul_fac = fac.r2l; end
         M_LR:    begin mul_smp = smp_l; mul_fac = fac.l2r; end
         M_RR:    begin mul_smp = smp_r; mul_fac = fac.r2r; end
         default: ;
      endcase
   end

   // Signed sample times zero-extended factor; the 25-bit result never overflows.
   always_comb begin
      mul_a    = {{9{mul_smp[15]}}, mul_smp};
      mul_b    = {17'd0, mul_fac};
      prod     = mul_a * mul_b;
      prod_ext = {prod[24], prod};
      sum_r    = acc_r + prod_ext;
   end

   // Datapath: capture on handshake, accumulate per step, load outputs leaving M_RR.
   always_ff @(posedge clk) begin
      if (reset) begin
         smp_l     <= '0;
         smp_r     <= '0;
         fac       <= '0;
         acc_l     <= '0;
         acc_r     <= '0;
         out_left  <= '0;
         out_right <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               smp_l <= in_left;
               smp_r <= in_right;
               fac   <= eff_vol;
               acc_l <= '0;
               acc_r <= '0;
            end
            M_LL: acc_l <= prod_ext;
            M_RL: acc_l <= acc_l + prod_ext;
            M_LR: acc_r <= prod_ext;
            M_RR: begin
               acc_r     <= sum_r;
               out_left  <= sat_shift(acc_l);
               out_right <= sat_shift(sum_r);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_volume_mixer.sv
// Self-checking bench for audio_volume_mixer: directed cases then random
// pairs, compared against an arithmetic mixing model.
module tb_audio_volume_mixer;
   import audio_volume_mixer_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   linear_volume_s     volume;
   logic               in_valid, in_ready, out_valid, out_ready;
   logic signed [15:0] in_left, in_right, out_left, out_right;

   int tests = 0;
   int fails = 0;
   int exp_l, exp_r;
`ifdef AUDIO_VOLUME_RAMP_EN
   linear_volume_s eff_m;
`endif

   audio_volume_mixer dut (
      .clk       (clk),
      .reset     (reset),
      .volume    (volume),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_left   (in_left),
      .in_right  (in_right),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_left  (out_left),
      .out_right (out_right)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Mixed sample = floor(sum / 128), clamped to 16-bit signed.
   function automatic int scale(input longint x);
      longint q;
      q = (x >= 0) ? x / 128 : -((-x + 127) / 128);
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   function automatic logic [7:0] toward(input logic [7:0] c, input logic [7:0] t);
      return (c < t) ? c + 8'd1 : (c > t) ? c - 8'd1 : c;
   endfunction

   // Offer a pair, wait for acceptance, and record the expected result.
   task automatic hs(input int l, input int r, input linear_volume_s v, input string tag);
      int n = 0;
      linear_volume_s f;
      @(negedge clk);
      in_left  = l[15:0];
      in_right = r[15:0];
      volume   = v;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      check({tag, "_accept"}, 32'(in_ready), 1);
      @(posedge clk);
`ifdef AUDIO_VOLUME_RAMP_EN
      f = eff_m;
      eff_m.l2l = toward(eff_m.l2l, v.l2l);
      eff_m.r2l = toward(eff_m.r2l, v.r2l);
      eff_m.l2r = toward(eff_m.l2r, v.l2r);
      eff_m.r2r = toward(eff_m.r2r, v.r2r);
`else
      f = v;
`endif
      exp_l = scale(longint'(l) * int'(f.l2l) + longint'(r) * int'(f.r2l));
      exp_r = scale(longint'(l) * int'(f.l2r) + longint'(r) * int'(f.r2r));
      #1 in_valid = 1'b0;
   endtask

   // Wait for the result, optionally change volume mid-flight and stall the consumer.
   task automatic wait_out(input string tag, input int hold, input int chg_at, input linear_volume_s vchg);
      int lat = 0;
      out_ready = (hold == 0);
      do begin
         @(negedge clk);
         lat++;
         if (lat == chg_at) volume = vchg;
      end while (!out_valid && lat < 20);
      check({tag, "_latency"}, lat, 5);
      check({tag, "_left"}, out_left, exp_l);
      check({tag, "_right"}, out_right, exp_r);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(out_valid), 1);
         check({tag, "_hold_ready"}, 32'(in_ready), 0);
         check({tag, "_hold_left"}, out_left, exp_l);
         check({tag, "_hold_right"}, out_right, exp_r);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_ready_after"}, 32'(in_ready), 1);
      check({tag, "_valid_after"}, 32'(out_valid), 0);
   endtask

   initial begin
      linear_volume_s unity, zero, half, full, rv;
      logic [15:0] rl, rr;
      unity = '{r2r: 8'h80, l2r: 8'h00, r2l: 8'h00, l2l: 8'h80};
      zero  = '0;
      half  = {4{8'h40}};
      full  = {4{8'hFF}};
`ifdef AUDIO_VOLUME_RAMP_EN
      eff_m = unity;
`endif
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_left = '0; in_right = '0; volume = unity;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_left", out_left, 0);
      check("rst_right", out_right, 0);
      check("rst_ready", 32'(in_ready), 1);

      hs(1234, -1234, unity, "unity");     wait_out("unity", 0, 0, unity);
      hs(1000, 3000, half, "mono");        wait_out("mono", 0, 0, half);
      hs(32767, 32767, full, "sat_pos");   wait_out("sat_pos", 0, 0, full);
      hs(-32768, -32768, full, "sat_neg"); wait_out("sat_neg", 0, 0, full);
      hs(-5000, 7000, unity, "bp");        wait_out("bp", 10, 0, unity);
      hs(321, -123, unity, "bp_next");     wait_out("bp_next", 0, 0, unity);
      hs(4000, -3000, unity, "inflight");  wait_out("inflight", 0, 2, zero);
      hs(4000, -3000, zero, "after_chg");  wait_out("after_chg", 0, 0, zero);

      // Reset while the pair is in M_LR discards it.
      hs(500, -700, unity, "rst_mid");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
`ifdef AUDIO_VOLUME_RAMP_EN
      eff_m = unity;
`endif
      check("rst_mid_valid", 32'(out_valid), 0);
      check("rst_mid_left", out_left, 0);
      check("rst_mid_right", out_right, 0);
      @(negedge clk);
      check("rst_mid_ready", 32'(in_ready), 1);
      hs(100, 200, unity, "post_rst");     wait_out("post_rst", 0, 0, unity);

      for (int i = 0; i < 40; i++) begin
         rl = 16'($urandom);
         rr = 16'($urandom);
         rv = $urandom;
         if (i % 8 == 0) rl = 16'h8000;
         if (i % 8 == 1) rr = 16'h7fff;
         hs(int'($signed(rl)), int'($signed(rr)), rv, "rand");
         wait_out("rand", int'($urandom_range(0, 3)), 0, rv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
